trafficlight_monitor: RTL and testbench
=======================================

TRAFFICLIGHT_MONITOR -- requirements
Module: trafficlight_monitor

Interface
REQ-001 Parameter GREEN_MAX, default 96: longest legal green phase, in clock cycles.
REQ-002 Parameter YELLOW_LEN, default 4: exact legal yellow phase length, in clock cycles.
REQ-003 Parameter RED_MAX, default 20: longest legal red phase, in clock cycles.
REQ-004 Port clock, input, 1: the only clock (1 s period in system use); all logic on rising edge.
REQ-005 Port reset, input, 1: synchronous, active-high reset.
REQ-006 Port M, input, 1: red lamp from the traffic light controller.
REQ-007 Port K, input, 1: yellow lamp.
REQ-008 Port H, input, 1: green lamp.
REQ-009 Port phase, output, 2: decoded phase; 0 = none/illegal, 1 = green, 2 = yellow, 3 = red.
REQ-010 Port dur, output, 8: cycles spent in the current phase, saturating at 255.
REQ-011 Port err_combo, output, 1: one-cycle pulse for an illegal lamp combination.
REQ-012 Port err_trans, output, 1: one-cycle pulse for an illegal phase transition.
REQ-013 Port err_time, output, 1: one-cycle pulse for a phase-duration violation.
REQ-014 Port err_count, output, 8: count of error cycles, saturating at 255.
REQ-015 Port fault, output, 1: sticky error flag.

Function
REQ-016 M, K and H shall be registered once per clock edge (s_M, s_K, s_H); all checks shall use the registered values; outputs update on the following edge (2-cycle input-to-output latency).
REQ-017 FSM states shall be IDLE, GREEN, YELLOW and RED; the phase output encodes the state, with IDLE = 0.
REQ-018 A registered sample with exactly one lamp high shall be legal; any other sample (none high, or two or more high) shall pulse err_combo, force IDLE and set dur to 0.
REQ-019 From IDLE, the first legal sample shall enter the matching state with dur = 1, with no transition or timing check.
REQ-020 Legal transitions shall be GREEN->YELLOW, YELLOW->RED, RED->YELLOW and YELLOW->GREEN; any other change between lit states (GREEN<->RED) shall pulse err_trans and still enter the new state with dur = 1.
REQ-021 While the sample is unchanged, dur shall increment by 1 per cycle, saturating at 255; on any state change, dur shall reload to 1.
REQ-022 GREEN overlong: err_time shall pulse once, on the cycle dur becomes GREEN_MAX+1.
REQ-023 RED overlong: err_time shall pulse once, on the cycle dur becomes RED_MAX+1.
REQ-024 YELLOW overlong: err_time shall pulse once, on the cycle dur becomes YELLOW_LEN+1.
REQ-025 YELLOW short: leaving YELLOW with final dur < YELLOW_LEN shall pulse err_time on the transition cycle.
REQ-026 A phase entered from IDLE is a partial phase; it shall be exempt from the REQ-025 short check but not from the overlong checks.
REQ-027 Simultaneous errors (e.g. err_trans plus err_time on one edge) shall all pulse in the same cycle.
REQ-028 err_count shall increment by exactly 1 in any cycle where at least one error pulses, and saturate at 255.
REQ-029 fault shall set on the first error pulse and hold until reset.

Reset
REQ-030 While reset is high at an edge: state = IDLE, input registers = 0, phase = 0, dur = 0, all err_* = 0, err_count = 0, fault = 0.
REQ-031 Reset asserted mid-phase shall discard all history; the first legal sample after release shall be treated as entry from IDLE (REQ-019, REQ-026).

Verification
REQ-032 Clean cycle: reset; then H for 96 cycles, K 4, M 20, K 4, H 10 -> phase sequence 1,2,3,2,1; dur peaks at 96/4/20/4; no err_*; err_count = 0.
REQ-033 Green overlong: H held for 100 cycles -> single err_time when dur = 97; dur reaches 100; err_count = 1; fault = 1.
REQ-034 Short yellow: H 10, K 3, M 5 -> err_time on the YELLOW->RED transition cycle; phase = 3 with dur = 1.
REQ-035 Illegal transition and combination: H 10 then M -> err_trans and phase = 3; then M and H both high for 2 cycles -> err_combo for 2 cycles, phase = 0, err_count = 3.
REQ-036 Reset mid-operation: M 15 with reset pulsed at cycle 8, then K 2, then M -> after reset all outputs 0; the K phase enters from IDLE, so its short length raises no err_time; err_count = 0.

Source files
------------

// File: rtl/trafficlight_monitor.sv
// Traffic light lamp monitor: registers the three lamp inputs, tracks the
// current phase and its duration, and flags illegal lamp combinations,
// illegal phase transitions and phase-duration violations.
module trafficlight_monitor #(
    parameter int unsigned GREEN_MAX  = 96,
    parameter int unsigned YELLOW_LEN = 4,
    parameter int unsigned RED_MAX    = 20
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       M,
    input  logic       K,
    input  logic       H,
    output logic [1:0] phase,
    output logic [7:0] dur,
    output logic       err_combo,
    output logic       err_trans,
    output logic       err_time,
    output logic [7:0] err_count,
    output logic       fault
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GREEN  = 2'd1,
        YELLOW = 2'd2,
        RED    = 2'd3
    } state_t;

    state_t      state_q, state_d;
    state_t      samp_state;
    logic        s_M, s_K, s_H;
    logic        s_vld;
    logic [1:0]  lit_cnt;
    logic        legal;
    logic [7:0]  dur_q, dur_d;
    logic        partial_q, partial_d;
    logic [31:0] cur_lim;
    logic        combo_d, trans_d, time_d;
    logic        any_err;

    // Input sample registers; s_vld marks that the sample was taken outside
    // reset, so the all-zero value left by reset is never judged as a
    // "no lamp lit" combination error.
    always_ff @(posedge clock) begin
        if (reset) begin
            s_M   <= 1'b0;
            s_K   <= 1'b0;
            s_H   <= 1'b0;
            s_vld <= 1'b0;
        end else begin
            s_M   <= M;
            s_K   <= K;
            s_H   <= H;
            s_vld <= 1'b1;
        end
    end

    // Decode the registered sample and select the overlong limit of the current phase.
    always_comb begin
        lit_cnt = 2'(s_M) + 2'(s_K) + 2'(s_H);
        legal   = (lit_cnt == 2'd1);
        if (s_H)      samp_state = GREEN;
        else if (s_K) samp_state = YELLOW;
        else          samp_state = RED;
        case (state_q)
            GREEN:   cur_lim = GREEN_MAX;
            YELLOW:  cur_lim = YELLOW_LEN;
            RED:     cur_lim = RED_MAX;
            default: cur_lim = '1;
        endcase
    end

    // State register: phase state, duration, partial-phase flag, error pulses and counters.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            dur_q     <= '0;
            partial_q <= 1'b0;
            err_combo <= 1'b0;
            err_trans <= 1'b0;
            err_time  <= 1'b0;
            err_count <= '0;
            fault     <= 1'b0;
        end else begin
            state_q   <= state_d;
            dur_q     <= dur_d;
            partial_q <= partial_d;
            err_combo <= combo_d;
            err_trans <= trans_d;
            err_time  <= time_d;
            if (any_err && (err_count != 8'hFF))
                err_count <= err_count + 8'd1;
            fault     <= fault | any_err;
        end
    end

    // Next-state logic: phase tracking plus combination, transition and timing checks.
    always_comb begin
        state_d   = state_q;
        dur_d     = dur_q;
        partial_d = partial_q;
        combo_d   = 1'b0;
        trans_d   = 1'b0;
        time_d    = 1'b0;
        if (s_vld) begin
            if (!legal) begin
                state_d   = IDLE;
                dur_d     = '0;
                partial_d = 1'b0;
                combo_d   = 1'b1;
            end else if (state_q == IDLE) begin
                state_d   = samp_state;
                dur_d     = 8'd1;
                partial_d = 1'b1;
            end else if (samp_state == state_q) begin
                if (dur_q != 8'hFF)
                    dur_d = dur_q + 8'd1;
                // Fires only on the step where dur becomes limit+1, hence once per phase.
                time_d = (32'(dur_q) == cur_lim) && (dur_q != 8'hFF);
            end else begin
                state_d   = samp_state;
                dur_d     = 8'd1;
                partial_d = 1'b0;
                trans_d   = ((state_q == GREEN) && (samp_state == RED)) ||
                            ((state_q == RED) && (samp_state == GREEN));
                time_d    = (state_q == YELLOW) && !partial_q &&
                            (32'(dur_q) < YELLOW_LEN);
            end
        end
        any_err = combo_d | trans_d | time_d;
    end

    // Output decode of the phase state and duration.
    always_comb begin
        phase = 2'(state_q);
        dur   = dur_q;
    end

endmodule

// File: tb/tb_trafficlight_monitor.sv
// Self-checking bench for trafficlight_monitor: a run-length behavioural model
// checked every cycle, plus directed scenarios with literal expectations.
module tb_trafficlight_monitor;

    localparam int GMAX = 96;
    localparam int YLEN = 4;
    localparam int RMAX = 20;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       M = 1'b0, K = 1'b0, H = 1'b0;
    logic [1:0] phase;
    logic [7:0] dur;
    logic       err_combo, err_trans, err_time;
    logic [7:0] err_count;
    logic       fault;

    int n_checks = 0;
    int n_fail   = 0;

    trafficlight_monitor #(
        .GREEN_MAX (GMAX),
        .YELLOW_LEN(YLEN),
        .RED_MAX   (RMAX)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .M        (M),
        .K        (K),
        .H        (H),
        .phase    (phase),
        .dur      (dur),
        .err_combo(err_combo),
        .err_trans(err_trans),
        .err_time (err_time),
        .err_count(err_count),
        .fault    (fault)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: phase number (0 none, 1 green, 2 yellow, 3 red),
    // unbounded run length, and whether the phase began from the idle state.
    int   md_ph, md_run, md_cnt;
    bit   md_from_idle, md_fault, md_combo, md_trans, md_time;
    bit   smp_v;
    bit [2:0] smp;   // {M,K,H} as sampled one edge earlier

    function automatic int limit_of(input int ph);
        case (ph)
            1:       return GMAX;
            2:       return YLEN;
            default: return RMAX;
        endcase
    endfunction

    task automatic model_step(input bit rst, input bit [2:0] in_mkh);
        int np;
        if (rst) begin
            md_ph = 0; md_run = 0; md_cnt = 0; md_from_idle = 0; md_fault = 0;
            md_combo = 0; md_trans = 0; md_time = 0; smp_v = 0; smp = 3'b000;
            return;
        end
        md_combo = 0; md_trans = 0; md_time = 0;
        if (smp_v) begin
            if ($countones(smp) != 1) begin
                md_ph = 0; md_run = 0; md_combo = 1;
            end else begin
                np = smp[0] ? 1 : (smp[1] ? 2 : 3);
                if (md_ph == 0) begin
                    md_ph = np; md_run = 1; md_from_idle = 1;
                end else if (np == md_ph) begin
                    md_run++;
                    if (md_run == limit_of(md_ph) + 1) md_time = 1;
                end else begin
                    if ((md_ph == 1 && np == 3) || (md_ph == 3 && np == 1)) md_trans = 1;
                    if (md_ph == 2 && !md_from_idle && md_run < YLEN) md_time = 1;
                    md_ph = np; md_run = 1; md_from_idle = 0;
                end
            end
            if (md_combo || md_trans || md_time) begin
                if (md_cnt < 255) md_cnt++;
                md_fault = 1;
            end
        end
        smp = in_mkh; smp_v = 1;
    endtask

    // Observation logs filled from the DUT outputs for the directed checks.
    int ph_log[$];
    int peak_log[$];
    int n_combo, n_trans, n_time;
    int time_dur, time_ph, trans_ph;
    int prev_phase = 0, prev_dur = 0;

    function automatic int qget(input int q[$], input int i);
        if (i < q.size()) return q[i];
        return -1;
    endfunction

    task automatic clear_logs();
        ph_log.delete(); peak_log.delete();
        n_combo = 0; n_trans = 0; n_time = 0;
        time_dur = -1; time_ph = -1; trans_ph = -1;
    endtask

    // Compare process: the inputs present at the falling edge are the ones the
    // preceding rising edge sampled, so the model steps here and is compared.
    initial begin
        forever begin
            @(negedge clock);
            model_step(reset, {M, K, H});
            check("cyc_phase",     int'(phase),     md_ph);
            check("cyc_dur",       int'(dur),       (md_run > 255) ? 255 : md_run);
            check("cyc_err_combo", int'(err_combo), int'(md_combo));
            check("cyc_err_trans", int'(err_trans), int'(md_trans));
            check("cyc_err_time",  int'(err_time),  int'(md_time));
            check("cyc_err_count", int'(err_count), md_cnt);
            check("cyc_fault",     int'(fault),     int'(md_fault));
            if (int'(phase) != prev_phase) begin
                ph_log.push_back(int'(phase));
                peak_log.push_back(prev_dur);
            end
            if (err_combo) n_combo++;
            if (err_trans) begin n_trans++; trans_ph = int'(phase); end
            if (err_time)  begin n_time++; time_dur = int'(dur); time_ph = int'(phase); end
            prev_phase = int'(phase);
            prev_dur   = int'(dur);
        end
    end

    task automatic drive(input bit m, input bit k, input bit h, input bit r, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            #1;
            M = m; K = k; H = h; reset = r;
        end
    endtask

    task automatic do_reset();
        drive(0, 0, 0, 1, 3);
    endtask

    // Two cycles of input-to-output latency, then settle past the compare process.
    task automatic flush();
        repeat (2) @(negedge clock);
        #2;
    endtask

    initial begin
        clear_logs();
        // Clean cycle through every legal transition at the exact limits.
        do_reset();
        clear_logs();
        drive(0, 0, 1, 0, 96);
        drive(0, 1, 0, 0, 4);
        drive(1, 0, 0, 0, 20);
        drive(0, 1, 0, 0, 4);
        drive(0, 0, 1, 0, 10);
        flush();
        check("clean_nphases", ph_log.size(), 5);
        check("clean_ph0", qget(ph_log, 0), 1);
        check("clean_ph1", qget(ph_log, 1), 2);
        check("clean_ph2", qget(ph_log, 2), 3);
        check("clean_ph3", qget(ph_log, 3), 2);
        check("clean_ph4", qget(ph_log, 4), 1);
        check("clean_green_peak", qget(peak_log, 1), 96);
        check("clean_yellow_peak", qget(peak_log, 2), 4);
        check("clean_red_peak", qget(peak_log, 3), 20);
        check("clean_yellow2_peak", qget(peak_log, 4), 4);
        check("clean_last_dur", int'(dur), 10);
        check("clean_errs", n_combo + n_trans + n_time, 0);
        check("clean_err_count", int'(err_count), 0);
        check("clean_fault", int'(fault), 0);

        // Green overlong.
        do_reset();
        check("reset_phase", int'(phase), 0);
        check("reset_dur", int'(dur), 0);
        check("reset_err_count", int'(err_count), 0);
        clear_logs();
        drive(0, 0, 1, 0, 100);
        flush();
        check("glong_ntime", n_time, 1);
        check("glong_time_dur", time_dur, 97);
        check("glong_dur", int'(dur), 100);
        check("glong_err_count", int'(err_count), 1);
        check("glong_fault", int'(fault), 1);

        // Short yellow flagged on the transition into red.
        do_reset();
        clear_logs();
        drive(0, 0, 1, 0, 10);
        drive(0, 1, 0, 0, 3);
        drive(1, 0, 0, 0, 5);
        flush();
        check("syel_ntime", n_time, 1);
        check("syel_time_phase", time_ph, 3);
        check("syel_time_dur", time_dur, 1);
        check("syel_dur", int'(dur), 5);
        check("syel_err_count", int'(err_count), 1);

        // Illegal transition followed by an illegal combination.
        do_reset();
        clear_logs();
        drive(0, 0, 1, 0, 10);
        drive(1, 0, 0, 0, 3);
        drive(1, 0, 1, 0, 2);
        drive(0, 0, 1, 0, 3);
        flush();
        check("ill_ntrans", n_trans, 1);
        check("ill_trans_phase", trans_ph, 3);
        check("ill_ncombo", n_combo, 2);
        check("ill_idle_phase", qget(ph_log, 2), 0);
        check("ill_err_count", int'(err_count), 3);
        check("ill_fault", int'(fault), 1);

        // Yellow and red overlong, each reported once.
        do_reset();
        clear_logs();
        drive(0, 0, 1, 0, 5);
        drive(0, 1, 0, 0, 6);
        drive(1, 0, 0, 0, 22);
        drive(0, 1, 0, 0, 4);
        drive(0, 0, 1, 0, 2);
        flush();
        check("long_ntime", n_time, 2);
        check("long_yellow_peak", qget(peak_log, 2), 6);
        check("long_red_peak", qget(peak_log, 3), 22);
        check("long_err_count", int'(err_count), 2);

        // Reset mid-red discards history; the following yellow starts from idle.
        do_reset();
        clear_logs();
        drive(1, 0, 0, 0, 7);
        drive(1, 0, 0, 1, 8);
        check("rst_mid_phase", int'(phase), 0);
        check("rst_mid_dur", int'(dur), 0);
        check("rst_mid_err_count", int'(err_count), 0);
        check("rst_mid_fault", int'(fault), 0);
        drive(0, 1, 0, 0, 2);
        drive(1, 0, 0, 0, 5);
        flush();
        check("rst_ph_seq_len", ph_log.size(), 4);
        check("rst_ph_yellow", qget(ph_log, 2), 2);
        check("rst_yellow_peak", qget(peak_log, 3), 2);
        check("rst_ntime", n_time, 0);
        check("rst_err_count", int'(err_count), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        n_fail++;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "timeout");
    end

endmodule
